// File: rtl/agu_sched.sv
// agu_sched: arbiter and sequencer for the address generation unit's two
// pointer registers (data pointer DC, code pointer CC).
//
// Two requesters share the unit: requester 0 is instruction fetch and
// requester 1 is load/store. A granted command becomes a short sequence of
// one-hot register strobes. 16-bit byte transfers take two cycles, low byte
// then high byte. TURN idle cycles follow every operation.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   r0_req/r0_op          requester 0 request and 3-bit command
//   r0_gnt/r0_done        requester 0 one-cycle grant / completion pulses
//   r1_req/r1_op          requester 1 request and 3-bit command
//   r1_gnt/r1_done        requester 1 one-cycle grant / completion pulses
//   dwe                   load DC from the address bus
//   drl, drh              drive DC[7:0] / DC[15:8] onto the data bus
//   cre                   drive CC onto the data bus
//   cwl, cwh              write CC[7:0] / CC[15:8] from the data bus
//   busy                  sequencer is not idle
//   owner                 requester currently or most recently granted
//   err                   one-cycle pulse when the granted op is illegal
//
// Every output is a flop. The next-cycle output values are computed
// together with the next state and registered in the same edge.
module agu_sched #(
  parameter int TURN       = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_req,
  input  logic [2:0] r0_op,
  output logic       r0_gnt,
  output logic       r0_done,
  input  logic       r1_req,
  input  logic [2:0] r1_op,
  output logic       r1_gnt,
  output logic       r1_done,
  output logic       dwe,
  output logic       drl,
  output logic       drh,
  output logic       cre,
  output logic       cwl,
  output logic       cwh,
  output logic       busy,
  output logic       owner,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    GAP  = 2'd3
  } state_t;

  // The gap counter is loaded with TURN-1 and counts down to zero.
  localparam int         TURN_M1  = (TURN > 0) ? (TURN - 1) : 0;
  localparam logic [1:0] GAP_INIT = 2'(TURN_M1);

  // Strobe vector layout: {dwe, drl, drh, cre, cwl, cwh}
  function automatic logic [5:0] first_strobe(input logic [2:0] op);
    case (op)
      3'd1:    first_strobe = 6'b100000;
      3'd2:    first_strobe = 6'b000100;
      3'd3:    first_strobe = 6'b010000;
      3'd4:    first_strobe = 6'b000010;
      3'd5:    first_strobe = 6'b000010;
      3'd6:    first_strobe = 6'b000001;
      default: first_strobe = 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] second_strobe(input logic [2:0] op);
    case (op)
      3'd3:    second_strobe = 6'b001000;
      3'd4:    second_strobe = 6'b000001;
      default: second_strobe = 6'b000000;
    endcase
  endfunction

  function automatic logic two_cycle(input logic [2:0] op);
    two_cycle = (op == 3'd3) || (op == 3'd4);
  endfunction

  function automatic logic illegal_op(input logic [2:0] op);
    illegal_op = (op == 3'd0) || (op == 3'd7);
  endfunction

  state_t     state_r, state_s;
  logic [2:0] op_r, op_s;
  logic [1:0] cnt_r, cnt_s;
  logic       last_r, last_s;
  logic       owner_r, owner_s;
  logic [5:0] strb_r, strb_s;
  logic [1:0] gnt_r, gnt_s;
  logic [1:0] done_r, done_s;
  logic       err_r, err_s;
  logic       busy_r, busy_s;
  logic       win_s;
  logic [2:0] win_op_s;

  // State, latched command and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      op_r    <= 3'd0;
      cnt_r   <= 2'd0;
      last_r  <= 1'b1;   // requester 0 wins the first tie
      owner_r <= 1'b0;
      strb_r  <= 6'd0;
      gnt_r   <= 2'd0;
      done_r  <= 2'd0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      owner_r <= owner_s;
      strb_r  <= strb_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
    end
  end

  // Arbitration, next state and next-cycle output values.
  always_comb begin
    state_s  = state_r;
    op_s     = op_r;
    cnt_s    = cnt_r;
    last_s   = last_r;
    owner_s  = owner_r;
    strb_s   = 6'd0;
    gnt_s    = 2'd0;
    done_s   = 2'd0;
    err_s    = 1'b0;
    win_s    = 1'b0;
    win_op_s = 3'd0;

    case (state_r)
      IDLE: begin
        if (r0_req || r1_req) begin
          if (r0_req && r1_req) begin
            // Tie: fixed priority favours requester 0, otherwise the
            // requester that did not win last time goes next.
            win_s = FIXED_PRIO ? 1'b0 : ~last_r;
          end else begin
            win_s = r1_req;
          end
          win_op_s       = win_s ? r1_op : r0_op;
          op_s           = win_op_s;
          last_s         = win_s;
          owner_s        = win_s;
          state_s        = S1;
          gnt_s[win_s]   = 1'b1;
          strb_s         = first_strobe(win_op_s);
          if (illegal_op(win_op_s)) begin
            err_s         = 1'b1;
            done_s[win_s] = 1'b1;
          end else if (!two_cycle(win_op_s)) begin
            done_s[win_s] = 1'b1;
          end else begin
            done_s = 2'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      S1: begin
        if (two_cycle(op_r)) begin
          state_s         = S2;
          strb_s          = second_strobe(op_r);
          done_s[owner_r] = 1'b1;
        end else if (TURN > 0) begin
          state_s = GAP;
          cnt_s   = GAP_INIT;
        end else begin
          state_s = IDLE;
        end
      end
      S2: begin
        if (TURN > 0) begin
          state_s = GAP;
          cnt_s   = GAP_INIT;
        end else begin
          state_s = IDLE;
        end
      end
      GAP: begin
        if (cnt_r == 2'd0) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  assign dwe     = strb_r[5];
  assign drl     = strb_r[4];
  assign drh     = strb_r[3];
  assign cre     = strb_r[2];
  assign cwl     = strb_r[1];
  assign cwh     = strb_r[0];
  assign r0_gnt  = gnt_r[0];
  assign r1_gnt  = gnt_r[1];
  assign r0_done = done_r[0];
  assign r1_done = done_r[1];
  assign err     = err_r;
  assign busy    = busy_r;
  assign owner   = owner_r;

endmodule

// File: doc/agu_sched.md
Name: agu_sched

Overview:
- Arbiter and sequencer for the address generation unit's two pointer registers: the 16-bit data pointer (DC) and the 16-bit code pointer (CC).
- Shares the unit between two requesters: requester 0 is instruction fetch, requester 1 is load/store.
- Translates each granted command into the unit's one-hot register strobes, splitting 16-bit byte transfers into low-then-high cycles.
- Inserts bus-turnaround idle cycles between operations.

Parameters:
- TURN, 1, idle cycles inserted after each operation before the next arbitration (legal 0..3).
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- r0_req  in  1  requester 0 request
- r0_op  in  3  requester 0 command
- r0_gnt  out  1  one-cycle grant pulse to requester 0
- r0_done  out  1  one-cycle completion pulse to requester 0
- r1_req, r1_op, r1_gnt, r1_done  as above, for requester 1
- dwe  out  1  strobe: load DC from address bus
- drl  out  1  strobe: drive DC[7:0] onto data bus
- drh  out  1  strobe: drive DC[15:8] onto data bus
- cre  out  1  strobe: drive CC onto data bus
- cwl  out  1  strobe: write CC[7:0] from data bus
- cwh  out  1  strobe: write CC[15:8] from data bus
- busy  out  1  high whenever state is not IDLE
- owner  out  1  index of the requester currently or last granted
- err  out  1  one-cycle pulse: granted op was illegal

Behaviour:
- All outputs are registered.
- Reset (rst=1, asynchronous) forces:
  - state=IDLE
  - all strobes, gnt, done, err and busy = 0
  - owner=0
  - last-winner register = 1, so requester 0 wins the first tie.
- Reset asserted mid-operation deasserts strobes immediately and abandons the operation; no done is issued.
- Op encoding:
  - 0 NOP: illegal
  - 1 WRDC: dwe, 1 cycle
  - 2 RDCC: cre, 1 cycle
  - 3 RDDC: drl then drh, 2 cycles
  - 4 LDCC: cwl then cwh, 2 cycles
  - 5 LDCCL: cwl, 1 cycle
  - 6 LDCCH: cwh, 1 cycle
  - 7: illegal
- States: IDLE, S1, S2, GAP.
- IDLE:
  - req/op are sampled only in IDLE, at the rising edge.
  - If any req is high, the winner's op is latched and state goes to S1; otherwise state stays IDLE.
  - Arbitration, round-robin: a single requester wins outright; with both requesting, the requester that is not the last winner wins. Last winner updates on each grant.
  - Arbitration, FIXED_PRIO=1: requester 0 wins every tie.
- S1 (first cycle after the sampling edge):
  - Winner's gnt=1 and owner is set.
  - The first strobe of the op is asserted.
  - For a 1-cycle op, the winner's done is also 1 in S1; the 2-cycle op case is covered under S2.
  - Illegal op in S1: no strobe; gnt, done and err all 1 in the same cycle.
- S1 exit: a 2-cycle op goes to S2. Otherwise state goes to GAP if TURN>0, else IDLE.
- S2: second strobe and done=1. Exit goes to GAP if TURN>0, else IDLE.
- GAP: all strobes 0 and busy=1. Counter runs TURN cycles, then state goes to IDLE.
- Latency: request-sampling edge to first strobe is 1 cycle.
  - Single op occupancy: 1 + TURN + 1 (IDLE) cycles.
  - 2-cycle op occupancy: 2 + TURN + 1 cycles.
- At most one strobe is high in any cycle. Strobes are never high in IDLE or GAP.
- Requester rules:
  - Hold req and op stable from assertion until done.
  - Deassert req no later than the IDLE cycle following done; a req still high at that IDLE sampling edge is a new request.
- Dropping req after grant does not abort; the op completes and done still pulses.
- The loser's req stays pending and is served at the next IDLE sample; there is no starvation under round-robin.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0, owner=0.
- r0_req=1, r0_op=4, TURN=1 -> cycle 1: r0_gnt=1, cwl=1. Cycle 2: cwh=1, r0_done=1. Cycle 3: GAP, busy=1, no strobes. Cycle 4: IDLE.
- Both req every cycle, r0_op=1, r1_op=2, round-robin -> grants alternate r0,r1,r0,r1; dwe and cre alternate. With FIXED_PRIO=1 -> only r0 granted while r0_req stays high.
- r1_op=7 -> single S1 cycle with r1_gnt=r1_done=err=1 and no strobes.
- r0_op=3, rst pulsed during drh cycle -> drh drops without waiting for the clock, no r0_done, state=IDLE. After release, r0_req=1 gives drl one cycle after the first sampling edge.
- TURN=0, r0 holds req high through done with op=5 -> cwl pulses repeat every 2 cycles (S1, IDLE); busy=0 only in the IDLE cycles.
